// File: rtl/rvcpu_arb_pkg.sv
// Shared definitions for the IF/MEM unified-RAM arbiter: FSM state and grant-owner encodings.
package rvcpu_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BUSY_IF  = 3'd1,
    ST_BUSY_MEM = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_RESP     = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_t;

  // Wide enough for MEM_STREAK_MAX up to 15.
  localparam int STREAK_W = 4;

endpackage

// File: rtl/pipeline_arb_perf_cnt.sv
// Arbiter performance counters: IF grants, MEM grants and stalled cycles; all wrap at 2^CNT_W.
module pipeline_arb_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_if_grant,
  input  logic             i_mem_grant,
  input  logic             i_stall,
  output logic [CNT_W-1:0] o_if_grants,
  output logic [CNT_W-1:0] o_mem_grants,
  output logic [CNT_W-1:0] o_stall_cycles
);

  logic [CNT_W-1:0] r_if_grants;
  logic [CNT_W-1:0] r_mem_grants;
  logic [CNT_W-1:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_grants    <= '0;
      r_mem_grants   <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (i_if_grant)  r_if_grants    <= r_if_grants + 1'b1;
      if (i_mem_grant) r_mem_grants   <= r_mem_grants + 1'b1;
      if (i_stall)     r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign o_if_grants    = r_if_grants;
  assign o_mem_grants   = r_mem_grants;
  assign o_stall_cycles = r_stall_cycles;

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates the IF fetch port and MEM load/store port onto one single-port RAM, with flush and stalls.
// Define ARB_PERF_CNT_EN to add the perf_if_grants/perf_mem_grants/perf_stall_cycles counters.
module pipeline_mem_arbiter
  import rvcpu_arb_pkg::*;
#(
  parameter int MEM_STREAK_MAX = 4,
  parameter int CNT_W          = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wmask,
  output logic [63:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_stall,
  output logic        ram_req,
  output logic        ram_we,
  output logic [63:0] ram_addr,
  output logic [63:0] ram_wdata,
  output logic [7:0]  ram_wmask,
  input  logic [63:0] ram_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [CNT_W-1:0] perf_if_grants,
  output logic [CNT_W-1:0] perf_mem_grants,
  output logic [CNT_W-1:0] perf_stall_cycles,
`endif
  input  logic        ram_ack
);

  arb_state_t           r_state;
  arb_state_t           w_next;
  arb_owner_t           r_own;
  logic [STREAK_W-1:0]  r_streak;
  logic [63:0]          r_ram_addr;
  logic                 r_ram_we;
  logic [63:0]          r_ram_wdata;
  logic [7:0]           r_ram_wmask;
  logic [31:0]          r_if_rdata;
  logic [63:0]          r_mem_rdata;
  logic                 w_grant_if;
  logic                 w_grant_mem;
  logic                 w_streak_full;

  assign w_streak_full = (r_streak == STREAK_W'(MEM_STREAK_MAX));

  always_comb begin
    w_next      = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // MEM has priority; a saturated streak hands the slot to a waiting fetch.
        w_grant_if  = if_req & ~if_flush & (~mem_req | w_streak_full);
        w_grant_mem = mem_req & ~w_grant_if;
        if (w_grant_if)       w_next = ST_BUSY_IF;
        else if (w_grant_mem) w_next = ST_BUSY_MEM;
      end
      ST_BUSY_IF: begin
        if (ram_ack)       w_next = if_flush ? ST_IDLE : ST_RESP;
        else if (if_flush) w_next = ST_DRAIN;
      end
      ST_BUSY_MEM: if (ram_ack) w_next = ST_RESP;
      ST_DRAIN:    if (ram_ack) w_next = ST_IDLE;
      ST_RESP:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_own       <= OWN_IF;
      r_streak    <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_if) begin
        r_own    <= OWN_IF;
        r_streak <= '0;
      end else if (w_grant_mem) begin
        r_own <= OWN_MEM;
        if (!if_req)             r_streak <= '0;
        else if (!w_streak_full) r_streak <= r_streak + 1'b1;
      end else if (r_state == ST_IDLE && !if_req) begin
        r_streak <= '0;
      end
      if (ram_ack && r_state == ST_BUSY_IF)
        r_if_rdata <= r_ram_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0];
      if (ram_ack && r_state == ST_BUSY_MEM)
        r_mem_rdata <= ram_rdata;
    end
  end

  // Request fields are captured once at grant and stay frozen until the access closes.
  always_ff @(posedge clk) begin
    if (w_grant_if) begin
      r_ram_addr  <= if_addr;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_ram_wmask <= '0;
    end else if (w_grant_mem) begin
      r_ram_addr  <= mem_addr;
      r_ram_we    <= mem_we;
      r_ram_wdata <= mem_wdata;
      r_ram_wmask <= mem_wmask;
    end
  end

  assign ram_req   = (r_state == ST_BUSY_IF) | (r_state == ST_BUSY_MEM) | (r_state == ST_DRAIN);
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_wmask = r_ram_wmask;

  assign if_valid  = (r_state == ST_RESP) & (r_own == OWN_IF) & ~if_flush;
  assign mem_valid = (r_state == ST_RESP) & (r_own == OWN_MEM);
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign if_stall  = if_req & ~if_valid;
  assign mem_stall = mem_req & ~mem_valid;

`ifdef ARB_PERF_CNT_EN
  pipeline_arb_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk            (clk),
    .reset          (reset),
    .i_if_grant     (w_grant_if & ~reset),
    .i_mem_grant    (w_grant_mem & ~reset),
    .i_stall        (if_stall | mem_stall),
    .o_if_grants    (perf_if_grants),
    .o_mem_grants   (perf_mem_grants),
    .o_stall_cycles (perf_stall_cycles)
  );
`endif

endmodule
